write_data: RTL and testbench
=============================

WRITE_DATA -- requirements
Module: write_data

Interface
REQ-001 SHALL have parameter RES_WIDTH, default 18, width of one result element.
REQ-002 SHALL have parameter ARRAY_W_W, default 4, rows of result matrix.
REQ-003 SHALL have parameter ARRAY_A_L, default 4, columns of result matrix.
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to snapshot and stream data_res.
REQ-007 SHALL have port data_res  input  [0:ARRAY_W_W-1][0:ARRAY_A_L-1][RES_WIDTH-1:0]  result matrix from the systolic array.
REQ-008 SHALL have port out_data  output  RES_WIDTH  current streamed element.
REQ-009 SHALL have port out_row  output  $clog2(ARRAY_W_W)  row index of out_data.
REQ-010 SHALL have port out_col  output  $clog2(ARRAY_A_L)  column index of out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_row/out_col valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-015 SHALL implement the states IDLE, SEND and DONE.
REQ-016 In IDLE with start=1, SHALL copy data_res into an internal snapshot register, clear row/col to 0 and enter SEND on the next edge.
REQ-017 SHALL assert out_valid only in SEND, holding element [0][0] in the first cycle after the start cycle (latency 1).
REQ-018 A beat SHALL transfer when out_valid=1 and out_ready=1 on a rising edge.
REQ-019 While out_valid=1 and out_ready=0, SHALL hold out_data, out_row and out_col stable.
REQ-020 SHALL stream elements in row-major order; on transfer col increments, and at col=ARRAY_A_L-1 col wraps to 0 and row increments.
REQ-021 On transfer of element [ARRAY_W_W-1][ARRAY_A_L-1], SHALL enter DONE, deassert out_valid and not wrap to [0][0].
REQ-022 In DONE, SHALL drive done=1 for exactly one cycle and then return to IDLE.
REQ-023 SHALL ignore start in SEND and DONE, leaving the snapshot unchanged.
REQ-024 Changes on data_res after the start cycle SHALL NOT affect the streamed values.
REQ-025 out_data SHALL be selected from the snapshot by row/col; the width is RES_WIDTH with no truncation or extension.
REQ-026 out_ready SHALL have no effect outside SEND.

Reset
REQ-027 While reset=1 (asynchronous), SHALL force the state to IDLE, row=0, col=0 and snapshot=0.
REQ-028 While reset=1, SHALL force out_valid=0, busy=0, done=0, out_data=0, out_row=0 and out_col=0.
REQ-029 Reset asserted mid-SEND SHALL abort the transfer with no done pulse; the next start after reset SHALL restart from [0][0].

Structure
REQ-030 The state typedef (IDLE/SEND/DONE) SHALL reside in the shared package systolic_pkg.
REQ-031 The index width constants SHALL be derived locally from the parameters.
REQ-032 A single sub-module rc_counter (row/col counter with enable, wrap and last flag) is natural; the remaining logic SHALL stay in write_data.

Verification
REQ-033 Scenario: data_res[i][j]=4*i+j, out_ready=1, start pulsed at cycle 0 -> beats 0..15 in cycles 1..16 with matching row/col, done=1 at cycle 17, busy=0 at cycle 18.
REQ-034 Scenario: out_ready toggling 1,0,1,0 -> each value held while ready=0, 16 distinct beats in order, no duplicates or losses, single done pulse.
REQ-035 Scenario: start re-pulsed at cycle 5 with data_res changed to all 0xFF -> stream unchanged (values 0..15), one done pulse.
REQ-036 Scenario: reset asserted at cycle 7 -> outputs 0 immediately (asynchronous), no done; new start -> stream restarts at [0][0] with value 0.
REQ-037 Scenario: start held high continuously -> start ignored in the DONE cycle, new snapshot taken in the first IDLE cycle, second stream begins one cycle later.
REQ-038 Scenario: ARRAY_W_W=2, ARRAY_A_L=3, RES_WIDTH=32, data_res[i][j]=0x80000000+3*i+j -> 6 beats with col wrapping at 2, full 32-bit values intact.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array result path.
//   state_t   : streaming controller states (IDLE / SEND / DONE)
//   idx_width : bit width needed to index n elements (never below 1)
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // A dimension of 1 still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to [0][0] (has priority over en)
//   en         : advance one element (column first, wrapping into the row)
//   row, col   : current position
//   last       : position is the final element [ROWS-1][COLS-1]
module rc_counter
  import systolic_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = idx_width(ROWS),
  parameter int COL_W = idx_width(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_W'(ROWS - 1));
  assign col_end = (col == COL_W'(COLS - 1));
  assign last    = row_end && col_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_data.sv
// Snapshots the systolic-array result matrix on start and streams it out
// one element per accepted beat in row-major order (valid/ready handshake).
//   clk, reset : clock, asynchronous active-high reset
//   start      : request a snapshot + stream (honoured only in IDLE)
//   data_res   : result matrix [row][col], RES_WIDTH bits per element
//   out_data   : current element, out_row/out_col its position
//   out_valid  : beat present (SEND only); out_ready accepts it
//   busy       : controller not idle
//   done       : one-cycle pulse after the final beat is accepted
module write_data
  import systolic_pkg::*;
#(
  parameter int RES_WIDTH = 18,
  parameter int ARRAY_W_W = 4,
  parameter int ARRAY_A_L = 4,
  localparam int ROW_W = idx_width(ARRAY_W_W),
  localparam int COL_W = idx_width(ARRAY_A_L)
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][RES_WIDTH-1:0]   data_res,
  output logic [RES_WIDTH-1:0]                                 out_data,
  output logic [ROW_W-1:0]                                     out_row,
  output logic [COL_W-1:0]                                     out_col,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic                                                 busy,
  output logic                                                 done
);

  state_t state;
  state_t state_nxt;

  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][RES_WIDTH-1:0] snap_p0;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;
  logic             load;
  logic             xfer;

  assign load = (state == IDLE) && start;
  assign xfer = (state == SEND) && out_ready;

  // Snapshot stage: data_res is captured once, so later changes on the
  // input cannot disturb a stream already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_p0 <= '0;
    end else if (load) begin
      snap_p0 <= data_res;
    end
  end

  // The counter is frozen on the final beat so it never wraps to [0][0];
  // the next load clears it.
  rc_counter #(
    .ROWS  (ARRAY_W_W),
    .COLS  (ARRAY_A_L),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_rc_counter (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .en    (xfer && !last),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (out_ready && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Element select stage: outputs are quiet (zero) whenever no beat is offered.
  always_comb begin
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == DONE);
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    if (state == SEND) begin
      out_data = snap_p0[row][col];
      out_row  = row;
      out_col  = col;
    end
  end

endmodule

// File: tb/tb_write_data.sv
module tb_write_data;

  logic clk;
  logic reset;

  // Default configuration: 4x4 of 18-bit elements
  logic                       start_a;
  logic                       ready_a;
  logic [0:3][0:3][17:0]      din_a;
  logic [17:0]                data_a;
  logic [1:0]                 row_a;
  logic [1:0]                 col_a;
  logic                       valid_a;
  logic                       busy_a;
  logic                       done_a;

  // Second configuration: 2x3 of 32-bit elements
  logic                       start_b;
  logic                       ready_b;
  logic [0:1][0:2][31:0]      din_b;
  logic [31:0]                data_b;
  logic [0:0]                 row_b;
  logic [1:0]                 col_b;
  logic                       valid_b;
  logic                       busy_b;
  logic                       done_b;

  write_data dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .data_res  (din_a),
    .out_data  (data_a),
    .out_row   (row_a),
    .out_col   (col_a),
    .out_valid (valid_a),
    .out_ready (ready_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  write_data #(
    .RES_WIDTH (32),
    .ARRAY_W_W (2),
    .ARRAY_A_L (3)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .data_res  (din_b),
    .out_data  (data_b),
    .out_row   (row_b),
    .out_col   (col_b),
    .out_valid (valid_b),
    .out_ready (ready_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model: a list of snapshot elements walked by a flat index.
  logic [17:0] m_snap [16];
  bit          m_act;
  bit          m_done;
  int          m_k;

  task automatic model_reset();
    m_act  = 0;
    m_done = 0;
    m_k    = 0;
    for (int n = 0; n < 16; n++) m_snap[n] = '0;
  endtask

  task automatic model_step(input bit st, input bit rdy);
    if (m_done) begin
      m_done = 0;
    end else if (m_act) begin
      if (rdy) begin
        if (m_k == 15) begin
          m_act  = 0;
          m_done = 1;
        end else begin
          m_k++;
        end
      end
    end else if (st) begin
      for (int n = 0; n < 16; n++) m_snap[n] = din_a[n / 4][n % 4];
      m_k   = 0;
      m_act = 1;
    end
  endtask

  task automatic check_a();
    chk("valid", 64'(valid_a), 64'(m_act));
    chk("busy", 64'(busy_a), 64'(m_act | m_done));
    chk("done", 64'(done_a), 64'(m_done));
    if (m_act) begin
      chk("data", 64'(data_a), 64'(m_snap[m_k]));
      chk("row", 64'(row_a), 64'(m_k / 4));
      chk("col", 64'(col_a), 64'(m_k % 4));
    end
  endtask

  task automatic cycle_a(input bit st, input bit rdy);
    start_a = st;
    ready_a = rdy;
    model_step(st, rdy);
    @(posedge clk);
    #1;
    check_a();
  endtask

  task automatic fill_ramp_a();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        din_a[i][j] = 18'(4 * i + j);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_a), 64'd0);
    chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_data"}, 64'(data_a), 64'd0);
    chk({tag, "_row"}, 64'(row_a), 64'd0);
    chk({tag, "_col"}, 64'(col_a), 64'd0);
  endtask

  typedef struct {
    bit          st;
    bit          rdy;
    bit          ev;
    logic [17:0] ed;
    int          er;
    int          ec;
    bit          eb;
    bit          edn;
  } vec_t;

  vec_t tbl [18];

  initial begin
    total   = 0;
    passed  = 0;
    start_a = 0;
    ready_a = 0;
    start_b = 0;
    ready_b = 1;
    din_a   = '0;
    din_b   = '0;
    model_reset();

    // Reset state
    reset = 1;
    #1;
    check_all_zero("rst");
    chk("rst_valid_b", 64'(valid_b), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;

    // Full-speed stream of the ramp matrix, expectations tabulated
    for (int n = 0; n < 18; n++) begin
      tbl[n].st  = (n == 0);
      tbl[n].rdy = 1;
      tbl[n].ev  = (n < 16);
      tbl[n].ed  = (n < 16) ? 18'(n) : 18'd0;
      tbl[n].er  = (n < 16) ? n / 4 : 0;
      tbl[n].ec  = (n < 16) ? n % 4 : 0;
      tbl[n].eb  = (n < 17);
      tbl[n].edn = (n == 16);
    end
    fill_ramp_a();
    for (int n = 0; n < 18; n++) begin
      start_a = tbl[n].st;
      ready_a = tbl[n].rdy;
      model_step(tbl[n].st, tbl[n].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", n), 64'(valid_a), 64'(tbl[n].ev));
      chk($sformatf("tbl%0d_busy", n), 64'(busy_a), 64'(tbl[n].eb));
      chk($sformatf("tbl%0d_done", n), 64'(done_a), 64'(tbl[n].edn));
      if (tbl[n].ev) begin
        chk($sformatf("tbl%0d_data", n), 64'(data_a), 64'(tbl[n].ed));
        chk($sformatf("tbl%0d_row", n), 64'(row_a), 64'(tbl[n].er));
        chk($sformatf("tbl%0d_col", n), 64'(col_a), 64'(tbl[n].ec));
      end
    end

    // Back-pressure: ready alternates, each value must hold while stalled
    cycle_a(1, 0);
    for (int n = 0; n < 36; n++) cycle_a(0, (n % 2) == 0);

    // Start re-pulsed mid-stream with changed input data is ignored
    cycle_a(1, 1);
    for (int n = 1; n < 5; n++) cycle_a(0, 1);
    din_a = {16{18'h000FF}};
    cycle_a(1, 1);
    fill_ramp_a();
    for (int n = 0; n < 14; n++) cycle_a(0, 1);

    // Asynchronous reset in the middle of a stream
    cycle_a(1, 1);
    for (int n = 1; n < 7; n++) cycle_a(0, 1);
    reset = 1;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #1;
    check_all_zero("arst_hold");
    reset = 0;
    model_reset();
    cycle_a(0, 1);
    cycle_a(1, 1);
    chk("restart_first", 64'(data_a), 64'd0);
    for (int n = 0; n < 17; n++) cycle_a(0, 1);

    // Start held high: back-to-back streams
    for (int n = 0; n < 40; n++) cycle_a(1, 1);
    cycle_a(0, 1);
    for (int n = 0; n < 20; n++) cycle_a(0, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          din_a[i][j] = 18'($urandom);
      cycle_a($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 40; n++) cycle_a(0, 1);

    // 2x3, 32-bit configuration
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        din_b[i][j] = 32'h8000_0000 + 32'(3 * i + j);
    start_b = 1;
    @(posedge clk);
    #1;
    start_b = 0;
    din_b   = '0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b%0d_valid", k), 64'(valid_b), 64'd1);
      chk($sformatf("b%0d_data", k), 64'(data_b), 64'h8000_0000 + 64'(k));
      chk($sformatf("b%0d_row", k), 64'(row_b), 64'(k / 3));
      chk($sformatf("b%0d_col", k), 64'(col_b), 64'(k % 3));
      chk($sformatf("b%0d_done", k), 64'(done_b), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("b_end_valid", 64'(valid_b), 64'd0);
    chk("b_end_done", 64'(done_b), 64'd1);
    @(posedge clk);
    #1;
    chk("b_idle_busy", 64'(busy_b), 64'd0);
    chk("b_idle_done", 64'(done_b), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
